// File: rtl/xctr_master.sv
// Burst master bridging a host command/stream interface onto a single-cycle
// control bus; reads are captured through a fixed-latency pending pipe.
module xctr_master #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_rnw,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [CNT_W-1:0]  cmd_len,
   input  logic              cmd_incr,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              ctr_req,
   output logic              ctr_rnw,
   output logic [ADDR_W-1:0] ctr_addr,
   output logic [DATA_W-1:0] data_to_wr,
   input  logic [DATA_W-1:0] data_to_rd
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                incr_q, incr_d;
   logic                ctr_req_q, ctr_req_d;
   logic                ctr_rnw_q, ctr_rnw_d;
   logic [ADDR_W-1:0]   ctr_addr_q, ctr_addr_d;
   logic [DATA_W-1:0]   data_to_wr_q, data_to_wr_d;
   logic                done_q, done_d;
   logic                rd_valid_q;
   logic [DATA_W-1:0]   rd_data_q;

   // pend_all[0] is the read request on the bus now; bit RD_LAT marks the
   // request whose data is on data_to_rd this cycle.
   logic [RD_LAT:0]     pend_all;
   logic                cap;
   logic                others_pending;

   assign pend_all[0] = ctr_req_q & ctr_rnw_q;
   assign cap         = pend_all[RD_LAT];

   if (RD_LAT > 0) begin : g_pipe
      logic [RD_LAT-1:0] pipe_q;
      always_ff @(posedge clk) begin
         if (rst) pipe_q <= '0;
         else     pipe_q <= pend_all[RD_LAT-1:0];
      end
      assign pend_all[RD_LAT:1] = pipe_q;
   end

   always_comb begin
      others_pending = 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
         others_pending = others_pending | pend_all[i];
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      incr_d       = incr_q;
      ctr_req_d    = 1'b0;
      ctr_rnw_d    = ctr_rnw_q;
      ctr_addr_d   = ctr_addr_q;
      data_to_wr_d = data_to_wr_q;
      done_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               cnt_d  = cmd_len;
               incr_d = cmd_incr;
               if (cmd_len == '0) done_d  = 1'b1;
               else               state_d = cmd_rnw ? READ : WRITE;
            end
         end
         WRITE: begin
            if (wr_valid && cnt_q != '0) begin
               ctr_req_d    = 1'b1;
               ctr_rnw_d    = 1'b0;
               ctr_addr_d   = addr_q;
               data_to_wr_d = wr_data;
               cnt_d        = cnt_q - CNT_W'(1);
               if (incr_q) addr_d = addr_q + ADDR_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         READ: begin
            if (cnt_q != '0) begin
               ctr_req_d  = 1'b1;
               ctr_rnw_d  = 1'b1;
               ctr_addr_d = addr_q;
               cnt_d      = cnt_q - CNT_W'(1);
               if (incr_q) addr_d = addr_q + ADDR_W'(1);
               if (cnt_q == CNT_W'(1)) state_d = DRAIN;
            end else begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // All requests are issued; finish as the final word is captured.
            if (cap && !others_pending) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         cnt_q        <= '0;
         incr_q       <= 1'b0;
         ctr_req_q    <= 1'b0;
         ctr_rnw_q    <= 1'b0;
         ctr_addr_q   <= '0;
         data_to_wr_q <= '0;
         done_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         cnt_q        <= cnt_d;
         incr_q       <= incr_d;
         ctr_req_q    <= ctr_req_d;
         ctr_rnw_q    <= ctr_rnw_d;
         ctr_addr_q   <= ctr_addr_d;
         data_to_wr_q <= data_to_wr_d;
         done_q       <= done_d;
         rd_valid_q   <= cap;
         if (cap) rd_data_q <= data_to_rd;
      end
   end

   assign cmd_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign wr_ready   = (state_q == WRITE) && (cnt_q != '0);
   assign rd_valid   = rd_valid_q;
   assign rd_data    = rd_data_q;
   assign done       = done_q;
   assign ctr_req    = ctr_req_q;
   assign ctr_rnw    = ctr_rnw_q;
   assign ctr_addr   = ctr_addr_q;
   assign data_to_wr = data_to_wr_q;

endmodule

// File: tb/tb_xctr_master.sv
// Scoreboard bench: three masters (RD_LAT 1, 0, 3) share one command/write
// stream; a per-instance bus model returns sequenced read data.
module tb_xctr_master;
   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_rnw = 1'b0, cmd_incr = 1'b0;
   logic [15:0] cmd_addr = '0;
   logic [7:0]  cmd_len = '0;
   logic        wr_valid = 1'b0;
   logic [31:0] wr_data = '0;

   logic        cmd_ready [NI];
   logic        wr_ready  [NI];
   logic        rd_valid  [NI];
   logic [31:0] rd_data   [NI];
   logic        busy      [NI];
   logic        done      [NI];
   logic        ctr_req   [NI];
   logic        ctr_rnw   [NI];
   logic [15:0] ctr_addr  [NI];
   logic [31:0] data_to_wr[NI];
   logic [31:0] data_to_rd[NI];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
      xctr_master #(.DATA_W(32), .ADDR_W(16), .CNT_W(8), .RD_LAT(L)) u_dut (
         .clk(clk), .rst(rst),
         .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[g]), .cmd_rnw(cmd_rnw),
         .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_incr(cmd_incr),
         .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready[g]),
         .rd_valid(rd_valid[g]), .rd_data(rd_data[g]),
         .busy(busy[g]), .done(done[g]),
         .ctr_req(ctr_req[g]), .ctr_rnw(ctr_rnw[g]), .ctr_addr(ctr_addr[g]),
         .data_to_wr(data_to_wr[g]), .data_to_rd(data_to_rd[g]));
   end

   typedef struct {
      logic [15:0] addr;
      logic        rnw;
      logic [31:0] data;
      logic        done_exp;
      logic        first;
      logic        last;
   } req_t;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      logic        last;
   } rd_t;

   req_t        req_q[$];
   rd_t         rd_q[NI][$];
   logic [31:0] slot[NI][8];
   req_t        me;
   rd_t         mr;
   int          cyc;
   int          checks;
   int          errors;
   int          done_cnt[NI];
   logic [31:0] rd_seq;
   int          last_rd_cyc;

   function automatic int lat(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Bus model and scoreboard consumer
   always @(negedge clk) begin
      if (!rst) begin
         if (ctr_req[0] || ctr_req[1] || ctr_req[2]) begin
            checks++;
            if (req_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_req cyc=%0d got req=%b%b%b required none",
                        cyc, ctr_req[0], ctr_req[1], ctr_req[2]);
            end else begin
               me = req_q.pop_front();
               for (int i = 0; i < NI; i++) begin
                  checks++;
                  if ({ctr_req[i], ctr_rnw[i], ctr_addr[i]} !== {1'b1, me.rnw, me.addr}) begin
                     errors++;
                     $display("FAIL req_fields inst%0d cyc=%0d got req/rnw/addr=%b/%b/%h required 1/%b/%h",
                              i, cyc, ctr_req[i], ctr_rnw[i], ctr_addr[i], me.rnw, me.addr);
                  end
                  checks++;
                  if (done[i] !== me.done_exp) begin
                     errors++;
                     $display("FAIL req_done inst%0d cyc=%0d got %b required %b", i, cyc, done[i], me.done_exp);
                  end
                  if (!me.rnw) begin
                     checks++;
                     if (data_to_wr[i] !== me.data) begin
                        errors++;
                        $display("FAIL wr_data inst%0d cyc=%0d got %h required %h", i, cyc, data_to_wr[i], me.data);
                     end
                  end else begin
                     slot[i][(cyc + lat(i)) % 8] = rd_seq;
                     rd_q[i].push_back('{data: rd_seq, cyc: cyc + lat(i) + 1, last: me.last});
                  end
               end
               if (me.rnw) begin
                  if (!me.first) begin
                     checks++;
                     if (cyc !== last_rd_cyc + 1) begin
                        errors++;
                        $display("FAIL rd_back_to_back cyc=%0d required %0d", cyc, last_rd_cyc + 1);
                     end
                  end
                  last_rd_cyc = cyc;
                  rd_seq = rd_seq + 32'd1;
               end
            end
         end
         for (int i = 0; i < NI; i++) begin
            data_to_rd[i] = slot[i][cyc % 8];
            slot[i][cyc % 8] = 32'hDEAD_0000 | 32'(cyc & 16'hFFFF);
            if (rd_valid[i]) begin
               checks++;
               if (rd_q[i].size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_rd inst%0d cyc=%0d got %h required none", i, cyc, rd_data[i]);
               end else begin
                  mr = rd_q[i].pop_front();
                  if (rd_data[i] !== mr.data || cyc !== mr.cyc || done[i] !== mr.last) begin
                     errors++;
                     $display("FAIL rd_word inst%0d got data/cyc/done=%h/%0d/%b required %h/%0d/%b",
                              i, rd_data[i], cyc, done[i], mr.data, mr.cyc, mr.last);
                  end
               end
            end
            if (done[i]) done_cnt[i]++;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (n < 1000 && !(busy[0] == 1'b0 && busy[1] == 1'b0 && busy[2] == 1'b0 &&
                           req_q.size() == 0 && rd_q[0].size() == 0 &&
                           rd_q[1].size() == 0 && rd_q[2].size() == 0)) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 1000) begin
         errors++;
         $display("FAIL idle_timeout got pending req=%0d required 0", req_q.size());
      end
   endtask

   task automatic push_burst(input logic rnw, input logic [15:0] addr, input int len,
                             input logic incr, input logic [31:0] wbase);
      logic [15:0] a = addr;
      for (int k = 0; k < len; k++) begin
         req_q.push_back('{addr: a, rnw: rnw, data: wbase + 32'(k),
                           done_exp: (!rnw && k == len - 1), first: (k == 0), last: (k == len - 1)});
         if (incr) a = a + 16'd1;
      end
   endtask

   task automatic start_cmd(input logic rnw, input logic [15:0] addr, input logic [7:0] len,
                            input logic incr, input logic keep);
      int   n = 0;
      logic acc;
      cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len; cmd_incr = incr;
      do begin
         acc = cmd_ready[0];
         @(negedge clk);
         n++;
      end while (!acc && n < 50);
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL cmd_accept got cmd_ready=0 required 1");
      end
      if (keep) begin
         cmd_rnw = 1'b1; cmd_addr = 16'h5A5A; cmd_len = 8'd5;
      end else begin
         cmd_valid = 1'b0;
      end
   endtask

   task automatic do_write(input logic [15:0] addr, input int len, input logic incr,
                           input logic [31:0] wbase, input int gap_at);
      int   d0[NI];
      int   k = 0, n = 0;
      logic acc, gapped = 1'b0;
      for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
      push_burst(1'b0, addr, len, incr, wbase);
      wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0;
      start_cmd(1'b0, addr, 8'(len), incr, 1'b1);
      while (k < len && n < 1000) begin
         if (k == gap_at && !gapped) begin
            wr_valid = 1'b0; gapped = 1'b1;
            @(negedge clk); n++;
            continue;
         end
         wr_valid = 1'b1; wr_data = wbase + 32'(k);
         acc = wr_ready[0];
         @(negedge clk); n++;
         if (acc) k++;
      end
      wr_valid = 1'b0; cmd_valid = 1'b0;
      checks++;
      if (k != len) begin
         errors++;
         $display("FAIL wr_accept got %0d words required %0d", k, len);
      end
      wait_idle();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (done_cnt[i] !== d0[i] + 1) begin
            errors++;
            $display("FAIL wr_done_count inst%0d got %0d required %0d", i, done_cnt[i] - d0[i], 1);
         end
      end
   endtask

   task automatic do_read(input logic [15:0] addr, input int len, input logic incr,
                          input logic [31:0] seq0);
      int d0[NI];
      for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
      rd_seq = seq0;
      push_burst(1'b1, addr, len, incr, '0);
      start_cmd(1'b1, addr, 8'(len), incr, 1'b0);
      wait_idle();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (done_cnt[i] !== d0[i] + 1) begin
            errors++;
            $display("FAIL rd_done_count inst%0d got %0d required %0d", i, done_cnt[i] - d0[i], 1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({ctr_req[i], ctr_rnw[i], ctr_addr[i], data_to_wr[i], rd_valid[i], rd_data[i],
              busy[i], done[i], wr_ready[i]} !== '0) begin
            errors++;
            $display("FAIL reset_outputs inst%0d got req=%b addr=%h wd=%h rv=%b rd=%h busy=%b done=%b wr=%b required all 0",
                     i, ctr_req[i], ctr_addr[i], data_to_wr[i], rd_valid[i], rd_data[i], busy[i], done[i], wr_ready[i]);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (cmd_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle inst%0d got cmd_ready/busy=%b/%b required 1/0", i, cmd_ready[i], busy[i]);
         end
      end
   endtask

   task automatic test_write_incr();
      do_write(16'h0010, 3, 1'b1, 32'hA000_000A, -1);
   endtask

   task automatic test_write_gap();
      do_write(16'h0200, 4, 1'b1, 32'hB0B0_0000, 1);
   endtask

   task automatic test_write_fixed_wrap();
      do_write(16'hFFFF, 2, 1'b0, 32'hC0DE_0000, -1);
      do_write(16'hFFFF, 2, 1'b1, 32'hC1DE_0000, -1);
   endtask

   task automatic test_read_fixed();
      do_read(16'h1000, 4, 1'b0, 32'h11);
   endtask

   task automatic test_read_wrap();
      do_read(16'hFFFE, 3, 1'b1, 32'h21);
   endtask

   task automatic test_read_long();
      do_read(16'h0100, 255, 1'b1, 32'h1000);
   endtask

   task automatic test_len0();
      int d0[NI];
      for (int i = 0; i < NI; i++) d0[i] = done_cnt[i];
      start_cmd(1'b0, 16'h1234, 8'd0, 1'b1, 1'b0);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (done[i] !== 1'b1 || cmd_ready[i] !== 1'b1 || busy[i] !== 1'b0) begin
            errors++;
            $display("FAIL len0_done inst%0d got done/ready/busy=%b/%b/%b required 1/1/0",
                     i, done[i], cmd_ready[i], busy[i]);
         end
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (done[i] !== 1'b0 || done_cnt[i] !== d0[i] + 1) begin
            errors++;
            $display("FAIL len0_pulse inst%0d got done=%b count=%0d required 0/1", i, done[i], done_cnt[i] - d0[i]);
         end
      end
   endtask

   task automatic test_reset_mid_read();
      int d0[NI];
      int n = 0;
      rd_seq = 32'h500;
      push_burst(1'b1, 16'h2000, 8, 1'b1, '0);
      start_cmd(1'b1, 16'h2000, 8'd8, 1'b1, 1'b0);
      while (req_q.size() > 5 && n < 50) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if ({ctr_req[i], ctr_rnw[i], ctr_addr[i], data_to_wr[i], rd_valid[i], rd_data[i],
              busy[i], done[i], wr_ready[i]} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs inst%0d got req=%b addr=%h rv=%b rd=%h busy=%b done=%b required all 0",
                     i, ctr_req[i], ctr_addr[i], rd_valid[i], rd_data[i], busy[i], done[i]);
         end
         rd_q[i].delete();
         for (int s = 0; s < 8; s++) slot[i][s] = 32'hDEAD_BEEF;
         d0[i] = done_cnt[i];
      end
      req_q.delete();
      rst = 1'b0;
      repeat (10) @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         checks++;
         if (done_cnt[i] !== d0[i] || cmd_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_quiet inst%0d got dones=%0d ready=%b required 0/1",
                     i, done_cnt[i] - d0[i], cmd_ready[i]);
         end
      end
      do_write(16'h3000, 2, 1'b1, 32'hE000_0000, -1);
      do_read(16'h3000, 2, 1'b1, 32'h600);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         data_to_rd[i] = 32'hDEAD_BEEF;
         for (int s = 0; s < 8; s++) slot[i][s] = 32'hDEAD_BEEF;
      end
      rd_seq = '0;
      test_reset();
      test_write_incr();
      test_write_gap();
      test_write_fixed_wrap();
      test_read_fixed();
      test_read_wrap();
      test_len0();
      test_read_long();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got running required finished");
      $fatal(1, "timeout");
   end
endmodule
